// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing and framebuffer reader. Sync, blank and frame_start are
// delayed to line up with pixel data returning from the framebuffer RAM.
module vga_scanout #(
  parameter int H_ACTIVE_VIDEO = 800,
  parameter int H_FRONT_PORCH = 40,
  parameter int H_SYNC_PULSE = 128,
  parameter int H_BACK_PORCH = 88,
  parameter int V_ACTIVE_VIDEO = 600,
  parameter int V_FRONT_PORCH = 1,
  parameter int V_SYNC_PULSE = 4,
  parameter int V_BACK_PORCH = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        rd_en,
  output logic [19:0] rd_addr,
  input  logic [23:0] rd_data,
  output logic [23:0] vga_color,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_pixel_clk,
  output logic        frame_start
);
  localparam logic [10:0] H_BLANK_PIX = 11'(H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [10:0] H_LAST = 11'(H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH + H_ACTIVE_VIDEO - 1);
  localparam logic [10:0] H_SYNC_START = 11'(H_FRONT_PORCH);
  localparam logic [10:0] H_SYNC_END = 11'(H_FRONT_PORCH + H_SYNC_PULSE);
  localparam logic [10:0] V_BLANK_PIX = 11'(V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [10:0] V_LAST = 11'(V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH + V_ACTIVE_VIDEO - 1);
  localparam logic [10:0] V_SYNC_START = 11'(V_FRONT_PORCH);
  localparam logic [10:0] V_SYNC_END = 11'(V_FRONT_PORCH + V_SYNC_PULSE);
  logic [10:0] count_h, count_v;
  logic [19:0] addr;
  logic clr, h_end, v_end, active, hs_raw, vs_raw, fs_raw;
  // each stage carries {frame_start, vsync, hsync, active} in active-high form
  logic [3:0] pipe [RD_LATENCY+1];
  assign vga_pixel_clk = ~clk;
  always_comb begin
    clr = reset || !en;
    h_end = count_h == H_LAST;
    v_end = count_v == V_LAST;
    active = count_h >= H_BLANK_PIX && count_v >= V_BLANK_PIX;
    hs_raw = count_h >= H_SYNC_START && count_h < H_SYNC_END;
    vs_raw = count_v >= V_SYNC_START && count_v < V_SYNC_END;
    fs_raw = count_h == 11'd0 && count_v == 11'd0;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      count_h <= '0;
      count_v <= '0;
      addr <= '0;
      rd_en <= 1'b0;
      rd_addr <= '0;
      vga_color <= '0;
      vga_hsync <= !SYNC_POL;
      vga_vsync <= !SYNC_POL;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      count_h <= h_end ? '0 : count_h + 11'd1;
      if (h_end) count_v <= v_end ? '0 : count_v + 11'd1;
      addr <= fs_raw ? '0 : active ? addr + 20'd1 : addr;
      rd_en <= active;
      if (active) rd_addr <= addr;
      pipe[0] <= {fs_raw, vs_raw, hs_raw, active};
      for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      vga_color <= pipe[RD_LATENCY][0] ? rd_data : '0;
      vga_blank_n <= pipe[RD_LATENCY][0];
      vga_hsync <= pipe[RD_LATENCY][1] ? SYNC_POL : !SYNC_POL;
      vga_vsync <= pipe[RD_LATENCY][2] ? SYNC_POL : !SYNC_POL;
      frame_start <= pipe[RD_LATENCY][3];
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: one full-size 800x600 instance plus two shrunken rasters at other read latencies,
// each fed by a RAM returning {4'h0, rd_addr}, with an expected-output queue per instance.
module tb_vga_scanout;
  typedef struct packed { logic [23:0] c; logic hs; logic vs; logic bn; logic fs; } out_t;
  localparam int LAT [3] = '{2, 1, 4};
  localparam int HA  [3] = '{800, 10, 10};
  localparam int HFP [3] = '{40, 2, 2};
  localparam int HSY [3] = '{128, 3, 3};
  localparam int HBP [3] = '{88, 3, 3};
  localparam int VA  [3] = '{600, 4, 4};
  localparam int VFP [3] = '{1, 1, 1};
  localparam int VSY [3] = '{4, 2, 2};
  localparam int VBP [3] = '{23, 2, 2};
  localparam out_t RST = '{c: 24'h0, hs: 1'b0, vs: 1'b0, bn: 1'b0, fs: 1'b0};

  logic clk = 1'b0, reset = 1'b1, en = 1'b1;
  always #5 clk = ~clk;

  logic        rd_en_w [3];
  logic [19:0] rd_addr_w [3];
  logic [23:0] rd_data_w [3], color_w [3];
  logic        hs_w [3], vs_w [3], bn_w [3], pclk_w [3], fs_w [3];
  out_t        exp_cur [3];
  bit          exp_ok [3];
  int pass_cnt = 0, total_cnt = 0;

  function automatic int hb(int g); return HFP[g] + HSY[g] + HBP[g]; endfunction
  function automatic int ht(int g); return hb(g) + HA[g]; endfunction
  function automatic int vb(int g); return VFP[g] + VSY[g] + VBP[g]; endfunction
  function automatic int vt(int g); return vb(g) + VA[g]; endfunction

  function automatic out_t model(int g, int h, int v);
    out_t o;
    logic act;
    act = h >= hb(g) && v >= vb(g);
    o.c = act ? 24'((v - vb(g)) * HA[g] + (h - hb(g))) : 24'h0;
    o.hs = h >= HFP[g] && h < HFP[g] + HSY[g];
    o.vs = v >= VFP[g] && v < VFP[g] + VSY[g];
    o.bn = act;
    o.fs = h == 0 && v == 0;
    return o;
  endfunction

  function automatic out_t actual(int g);
    return {color_w[g], hs_w[g], vs_w[g], bn_w[g], fs_w[g]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int L = LAT[g];
    logic [23:0] ram_q [L];
    out_t q [$];
    int mh = 0, mv = 0, hold = 0;
    vga_scanout #(
      .H_ACTIVE_VIDEO(HA[g]), .H_FRONT_PORCH(HFP[g]), .H_SYNC_PULSE(HSY[g]), .H_BACK_PORCH(HBP[g]),
      .V_ACTIVE_VIDEO(VA[g]), .V_FRONT_PORCH(VFP[g]), .V_SYNC_PULSE(VSY[g]), .V_BACK_PORCH(VBP[g]),
      .SYNC_POL(1'b1), .RD_LATENCY(L)
    ) dut (
      .clk(clk), .reset(reset), .en(en), .rd_en(rd_en_w[g]), .rd_addr(rd_addr_w[g]),
      .rd_data(rd_data_w[g]), .vga_color(color_w[g]), .vga_hsync(hs_w[g]), .vga_vsync(vs_w[g]),
      .vga_blank_n(bn_w[g]), .vga_pixel_clk(pclk_w[g]), .frame_start(fs_w[g])
    );
    // RAM returns a poison value for unrequested cycles so misaligned reads show up
    always @(posedge clk) begin
      ram_q[0] <= rd_en_w[g] ? {4'h0, rd_addr_w[g]} : 24'hFFFFFF;
      for (int k = 1; k < L; k++) ram_q[k] <= ram_q[k-1];
    end
    assign rd_data_w[g] = ram_q[L-1];
    // expected output for the current raster position becomes visible L+2 cycles later;
    // a clear forces reset values onto everything still in flight
    always @(posedge clk) begin
      q.push_back((reset || !en) ? RST : model(g, mh, mv));
      if (reset || !en) begin
        mh <= 0;
        mv <= 0;
        hold <= L + 1;
      end else begin
        mh <= (mh == ht(g) - 1) ? 0 : mh + 1;
        if (mh == ht(g) - 1) mv <= (mv == vt(g) - 1) ? 0 : mv + 1;
        hold <= (hold > 0) ? hold - 1 : 0;
      end
      if (q.size() == L + 2) begin
        exp_cur[g] <= (reset || !en || hold > 0) ? RST : q[0];
        exp_ok[g] <= 1'b1;
        void'(q.pop_front());
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total_cnt++;
      if ({rd_en_w[g], rd_addr_w[g], actual(g)} !== {1'b0, 20'h0, RST})
        $display("FAIL reset_values dut%0d got %h want %h", g, {rd_en_w[g], rd_addr_w[g], actual(g)}, {1'b0, 20'h0, RST});
      else pass_cnt++;
      total_cnt++;
      if (pclk_w[g] !== 1'b1) $display("FAIL pixel_clk dut%0d got %b want 1 while clk low", g, pclk_w[g]);
      else pass_cnt++;
    end
  endtask

  task automatic test_first_pixel();
    int first_rd = -1, first_bn = -1;
    logic [19:0] addr0;
    logic [23:0] col0;
    reset = 1'b0;
    for (int k = 1; k <= 29900; k++) begin
      @(negedge clk);
      if (first_rd < 0 && rd_en_w[0] === 1'b1) begin first_rd = k; addr0 = rd_addr_w[0]; end
      if (first_bn < 0 && bn_w[0] === 1'b1) begin first_bn = k; col0 = color_w[0]; end
    end
    total_cnt++;
    if (first_rd !== 29825) $display("FAIL first_rd_en_cycle got %0d want 29825", first_rd); else pass_cnt++;
    total_cnt++;
    if (addr0 !== 20'd0) $display("FAIL first_rd_addr got %0d want 0", addr0); else pass_cnt++;
    total_cnt++;
    if (first_bn !== 29828) $display("FAIL first_blank_n_cycle got %0d want 29828", first_bn); else pass_cnt++;
    total_cnt++;
    if (col0 !== 24'd0) $display("FAIL first_color got %h want 0", col0); else pass_cnt++;
  endtask

  task automatic test_pixel_alignment(int n);
    repeat (n) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (exp_ok[g]) begin
        total_cnt++;
        if (actual(g) !== exp_cur[g])
          $display("FAIL pixel_align dut%0d t=%0t got %h want %h", g, $time, actual(g), exp_cur[g]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_line_timing();
    for (int g = 0; g < 2; g++) begin
      int k, off, len;
      for (k = 0; k < 3000 && bn_w[g] !== 1'b1; k++) @(negedge clk);
      for (k = 0; k < 3000 && bn_w[g] !== 1'b0; k++) @(negedge clk);
      for (off = 0; off < 3000 && hs_w[g] !== 1'b1; off++) @(negedge clk);
      for (len = 0; len < 3000 && hs_w[g] === 1'b1; len++) @(negedge clk);
      total_cnt++;
      if (off !== HFP[g]) $display("FAIL hsync_offset dut%0d got %0d want %0d", g, off, HFP[g]); else pass_cnt++;
      total_cnt++;
      if (len !== HSY[g]) $display("FAIL hsync_width dut%0d got %0d want %0d", g, len, HSY[g]); else pass_cnt++;
    end
    for (int g = 1; g < 3; g++) begin
      int k, len;
      for (k = 0; k < 1000 && vs_w[g] !== 1'b0; k++) @(negedge clk);
      for (k = 0; k < 1000 && vs_w[g] !== 1'b1; k++) @(negedge clk);
      for (len = 0; len < 1000 && vs_w[g] === 1'b1; len++) @(negedge clk);
      total_cnt++;
      if (len !== VSY[g] * ht(g)) $display("FAIL vsync_width dut%0d got %0d want %0d", g, len, VSY[g] * ht(g));
      else pass_cnt++;
    end
  endtask

  task automatic test_frames();
    for (int g = 1; g < 3; g++) begin
      int k, wraps;
      int period [2], strobes [2];
      logic [19:0] prev;
      logic [23:0] last_col;
      wraps = 0;
      last_col = 24'hx;
      for (k = 0; k < 1000 && fs_w[g] !== 1'b1; k++) @(negedge clk);
      prev = rd_addr_w[g];
      for (int f = 0; f < 2; f++) begin
        period[f] = 0;
        strobes[f] = 0;
        do begin
          @(negedge clk);
          period[f]++;
          if (rd_en_w[g] === 1'b1) strobes[f]++;
          if (rd_en_w[g] === 1'b1 && rd_addr_w[g] == 20'd0 && prev == 20'(HA[g] * VA[g] - 1)) wraps++;
          prev = rd_addr_w[g];
          if (bn_w[g] === 1'b1) last_col = color_w[g];
        end while (fs_w[g] !== 1'b1 && period[f] < 2000);
      end
      for (int f = 0; f < 2; f++) begin
        total_cnt++;
        if (period[f] !== ht(g) * vt(g)) $display("FAIL frame_period dut%0d got %0d want %0d", g, period[f], ht(g) * vt(g));
        else pass_cnt++;
      end
      total_cnt++;
      if (strobes[0] !== HA[g] * VA[g]) $display("FAIL rd_strobes dut%0d got %0d want %0d", g, strobes[0], HA[g] * VA[g]);
      else pass_cnt++;
      total_cnt++;
      if (wraps !== 2) $display("FAIL addr_wrap dut%0d got %0d want 2", g, wraps); else pass_cnt++;
      total_cnt++;
      if (last_col !== 24'(HA[g] * VA[g] - 1)) $display("FAIL last_pixel dut%0d got %0d want %0d", g, last_col, HA[g] * VA[g] - 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_en_drop();
    int first_fs [3];
    for (int k = 0; k < 500 && rd_en_w[1] !== 1'b1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0 || c == 9) for (int g = 0; g < 3; g++) begin
        total_cnt++;
        if ({rd_en_w[g], rd_addr_w[g], actual(g)} !== {1'b0, 20'h0, RST})
          $display("FAIL en_low_outputs dut%0d cyc%0d got %h want %h", g, c, {rd_en_w[g], rd_addr_w[g], actual(g)}, {1'b0, 20'h0, RST});
        else pass_cnt++;
      end
    end
    en = 1'b1;
    first_fs = '{-1, -1, -1};
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (first_fs[g] < 0 && fs_w[g] === 1'b1) first_fs[g] = k;
    end
    for (int g = 0; g < 3; g++) begin
      total_cnt++;
      if (first_fs[g] !== LAT[g] + 2) $display("FAIL restart_frame_start dut%0d got %0d want %0d", g, first_fs[g], LAT[g] + 2);
      else pass_cnt++;
    end
    test_pixel_alignment(400);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 500 && !(rd_en_w[1] === 1'b1 && rd_addr_w[1] == 20'(2 * HA[1] + 4)); k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total_cnt++;
      if ({rd_en_w[g], rd_addr_w[g], actual(g)} !== {1'b0, 20'h0, RST})
        $display("FAIL reset_mid_frame dut%0d got %h want %h", g, {rd_en_w[g], rd_addr_w[g], actual(g)}, {1'b0, 20'h0, RST});
      else pass_cnt++;
    end
    reset = 1'b0;
    test_pixel_alignment(400);
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_pixel_alignment(400);
    test_line_timing();
    test_frames();
    test_en_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Framebuffer reader and VGA timing generator. Generates 800x600 raster timing, issues sequential read requests to the pixel framebuffer RAM for every active pixel, and drives the VGA pins with colour, sync and blank, all aligned through a fixed-latency pipeline. It is the display-side consumer of the framebuffer that the CPU-side pixel writer fills.

## Interface
- H_ACTIVE_VIDEO, 800, active pixels per line
- H_FRONT_PORCH, 40; H_SYNC_PULSE, 128; H_BACK_PORCH, 88 (H_BLANK_PIX = 256, H_TOTAL_PIX = 1056)
- V_ACTIVE_VIDEO, 600, active lines per frame
- V_FRONT_PORCH, 1; V_SYNC_PULSE, 4; V_BACK_PORCH, 23 (V_BLANK_PIX = 28, V_TOTAL_PIX = 628)
- SYNC_POL, 1, active level of hsync/vsync
- RD_LATENCY, 2, cycles from rd_en sampled by the RAM to rd_data valid (legal range 1..4)
- clk  in  1  pixel clock; one clock, all logic on posedge
- reset  in  1  synchronous, active-high
- en  in  1  scanout enable
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  20  framebuffer pixel index (row-major, 0..479999)
- rd_data  in  24  RGB from the framebuffer, valid RD_LATENCY cycles after rd_en
- vga_color  out  24  pixel colour
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- vga_blank_n  out  1  low during blanking
- vga_pixel_clk  out  1  ~clk (combinational)
- frame_start  out  1  one-cycle pulse aligned with output of raster position (0,0)

## Operation
- Counters countH (11 b, 0..1055) and countV (11 b, 0..627); blanking is at the start of each line/frame: front porch, sync, back porch, then active.
- countH increments every enabled cycle; at 1055 wraps to 0 and countV increments; countV at 627 wraps to 0.
- Raw hsync active when 40 <= countH < 168; raw vsync active when 1 <= countV < 5; active = countH >= 256 && countV >= 28.
- Address counter (20 b): increments by 1 each active cycle; cleared to 0 when countH = 0 and countV = 0. No multiplier. Active pixel (x,y) reads index y*800 + x.
- rd_en asserted only for active positions; rd_addr holds its last value when rd_en is low.
- vga_color = rd_data when delayed active is 1, else 24'h0.
- en low: counters, address counter and whole pipeline cleared next cycle (same state as reset); outputs remain at reset values while low. en rising restarts the frame from (0,0).
- reset overrides en; reset mid-frame returns everything to reset values next cycle, no partial-frame output afterwards.
- Reset values: countH = countV = 0, address 0, rd_en 0, rd_addr 0, vga_color 0, vga_hsync = vga_vsync = ~SYNC_POL, vga_blank_n 0, frame_start 0; all pipeline stages hold blank/inactive-sync.

## Timing
- Cycle n: counters hold (h,v).
- Cycle n+1: rd_en/rd_addr for (h,v) registered.
- Cycle n+1+RD_LATENCY: rd_data for (h,v).
- Cycle n+2+RD_LATENCY: vga_color, vga_hsync, vga_vsync, vga_blank_n, frame_start for (h,v) registered together. Sync/blank/frame_start travel through a delay line of length 2+RD_LATENCY matching the data path.
- Output line period 1056 cycles, frame period 663168 cycles, 480000 rd_en strobes per frame.
- First cycle after reset release with en=1 counts as counter state (0,0).

## Test plan
- Reset held 5 cycles, en=1 -> all outputs at reset values; vga_hsync = vga_vsync = 0 with SYNC_POL=1.
- Release reset, RD_LATENCY=2, RAM model returns rd_data = {4'h0, rd_addr} -> first rd_en at cycle 29825 (counter (256,28) at 29824) with rd_addr 0; vga_blank_n first high at cycle 29828 with vga_color 0; pixel (799,599) carries colour 479999.
- Line timing -> vga_hsync high for exactly 128 cycles per line, starting 40 cycles after blanking begins; vga_vsync high for 4 lines (4224 cycles) per frame.
- Two full frames -> frame_start pulses exactly 663168 cycles apart; rd_addr wraps 479999 -> 0; 480000 rd_en strobes per frame.
- en dropped mid-active-line for 10 cycles then raised -> outputs blank/inactive sync within 1 cycle plus pipeline flush; frame restarts with frame_start 663168 later-consistent from new (0,0).
- reset pulsed at countH=500, countV=300 -> next cycle all outputs at reset values; RD_LATENCY=1 and 4 repeat pixel-alignment check (colour matches address at every active output).
